// File: rtl/multiword_add_sequencer_if.sv
// Operand/result handshake bundle for the multiword add sequencer.
// The slave side is the adder; the master side offers operands and takes results.
interface multiword_add_sequencer_if #(
  parameter int N     = 4,
  parameter int WORDS = 4
);
  localparam int W = N * WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in1;
  logic [W-1:0] in2;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output in_valid, in1, in2, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, in1, in2, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/multiword_add_sequencer.sv
// Bit-serial-by-slice adder: one N-bit slice of a W-bit add per cycle,
// result held until the consumer takes it.
module multiword_add_sequencer #(
  parameter int N     = 4,
  parameter int WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  multiword_add_sequencer_if.slave  bus
);
  localparam int              IW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0]   LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_e;

  state_e                  state_q;
  logic [WORDS-1:0][N-1:0] a_q, b_q, sum_q;
  logic [IW-1:0]           idx_q;
  logic                    carry_q;
  logic                    cout_q, ovf_q;
  logic                    in_ready_q, out_valid_q;

  logic [N-1:0]            a_sl, b_sl;
  logic [N:0]              slice_d;

  always_comb begin
    a_sl    = a_q[idx_q];
    b_sl    = b_q[idx_q];
    slice_d = {1'b0, a_sl} + {1'b0, b_sl} + {{N{1'b0}}, carry_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in1;
            b_q        <= bus.in2;
            carry_q    <= bus.cin;
            idx_q      <= '0;
            sum_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          sum_q[idx_q] <= slice_d[N-1:0];
          carry_q      <= slice_d[N];
          if (idx_q == LAST) begin
            // Top slice's sum MSB is bit W-1 of the full result.
            cout_q      <= slice_d[N];
            ovf_q       <= (a_q[WORDS-1][N-1] == b_q[WORDS-1][N-1]) &&
                           (slice_d[N-1] != a_q[WORDS-1][N-1]);
            idx_q       <= '0;
            out_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Bench for multiword_add_sequencer: transaction-level reference model checked
// every cycle, plus directed literal cases and a randomized handshake run.
module tb_multiword_add_sequencer;
  localparam int N     = 4;
  localparam int WORDS = 4;
  localparam int W     = N * WORDS;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multiword_add_sequencer_if #(.N(N), .WORDS(WORDS)) bus ();

  multiword_add_sequencer #(.N(N), .WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // {ovf, cout, sum} from whole-word arithmetic
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic c);
    logic [W:0] s;
    logic       o;
    s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    o = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {o, s};
  endfunction

  // Transaction-level model: idle / busy for WORDS edges / holding a result
  bit           m_rdy = 1'b1, m_vld = 1'b0, chk_en = 1'b0;
  int           m_cnt = 0, cyc = 0, last_acc = -1, n_acc = 0;
  logic [W-1:0] m_sum = '0, p_sum = '0;
  logic         m_cout = 1'b0, m_ovf = 1'b0, p_cout = 1'b0, p_ovf = 1'b0;

  always @(posedge clk) begin
    logic [W+1:0] r;
    cyc++;
    if (!rst_n) begin
      m_rdy = 1'b1; m_vld = 1'b0; m_cnt = 0;
      m_sum = '0; m_cout = 1'b0; m_ovf = 1'b0;
      last_acc = -1; chk_en = 1'b1;
    end else if (m_rdy) begin
      if (bus.in_valid) begin
        r = ref_add(bus.in1, bus.in2, bus.cin);
        {p_ovf, p_cout, p_sum} = r;
        m_rdy = 1'b0; m_cnt = WORDS; m_sum = '0;
        if (last_acc >= 0) chk("accept_gap", 64'((cyc - last_acc) >= WORDS + 2), 64'd1);
        last_acc = cyc;
        n_acc++;
      end
    end else if (!m_vld) begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_vld = 1'b1; m_sum = p_sum; m_cout = p_cout; m_ovf = p_ovf;
      end
    end else if (bus.out_ready) begin
      m_vld = 1'b0; m_rdy = 1'b1;
    end
  end

  // Per-cycle compare; result fields are meaningful outside the busy window
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", 64'(bus.in_ready), 64'(m_rdy));
      chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
      if (m_rdy || m_vld) begin
        chk("sum", 64'(bus.sum), 64'(m_sum));
        chk("cout", 64'(bus.cout), 64'(m_cout));
        chk("ovf", 64'(bus.ovf), 64'(m_ovf));
      end
    end
  end

  task automatic wait_result(input string nm, input logic [W-1:0] es, input logic ec,
                             input logic eo);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
    chk({nm, "_latency"}, 64'(n), 64'(WORDS + 1));
    chk({nm, "_sum"}, 64'(bus.sum), 64'(es));
    chk({nm, "_cout"}, 64'(bus.cout), 64'(ec));
    chk({nm, "_ovf"}, 64'(bus.ovf), 64'(eo));
    bus.out_ready = 1'b1;
    @(posedge clk);
    #2 bus.out_ready = 1'b0;
  endtask

  task automatic run_one(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W-1:0] es, input logic ec,
                         input logic eo);
    @(posedge clk);
    #2;
    bus.in_valid = 1'b1; bus.in1 = a; bus.in2 = b; bus.cin = c;
    @(posedge clk);
    #2 bus.in_valid = 1'b0;
    wait_result(nm, es, ec, eo);
  endtask

  initial begin
    int base;
    bus.in_valid = 1'b0; bus.in1 = '0; bus.in2 = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Pin the reference model to hand-computed values
    chk("model_carry", 64'(ref_add(16'hFFFF, 16'h0001, 1'b0)), 64'({1'b0, 1'b1, 16'h0000}));
    chk("model_cin",   64'(ref_add(16'h1234, 16'h4321, 1'b1)), 64'({1'b0, 1'b0, 16'h5556}));
    chk("model_povf",  64'(ref_add(16'h7FFF, 16'h0001, 1'b0)), 64'({1'b1, 1'b0, 16'h8000}));
    chk("model_novf",  64'(ref_add(16'h8000, 16'h8000, 1'b0)), 64'({1'b1, 1'b1, 16'h0000}));

    run_one("carry_chain", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("with_cin",    16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    run_one("pos_ovf",     16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_one("neg_ovf",     16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // Stall in HOLD while new operands are offered; they must not be taken
    @(posedge clk);
    #2;
    bus.in_valid = 1'b1; bus.in1 = 16'h00F0; bus.in2 = 16'h0F10; bus.cin = 1'b0;
    @(posedge clk);
    #2 bus.in_valid = 1'b0;
    begin
      int n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!bus.out_valid && n < 20);
    end
    bus.in_valid = 1'b1; bus.in1 = 16'h0003; bus.in2 = 16'h0004; bus.cin = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_sum", 64'(bus.sum), 64'h1000);
      chk("hold_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #2 bus.out_ready = 1'b0;
    @(posedge clk);
    #2 bus.in_valid = 1'b0;
    wait_result("after_hold", 16'h0007, 1'b0, 1'b0);

    // Reset during the second RUN cycle aborts the add
    @(posedge clk);
    #2;
    bus.in_valid = 1'b1; bus.in1 = 16'hABCD; bus.in2 = 16'h1111; bus.cin = 1'b1;
    @(posedge clk);
    #2 bus.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_sum", 64'(bus.sum), 64'd0);
    chk("rst_cout", 64'(bus.cout), 64'd0);
    chk("rst_ovf", 64'(bus.ovf), 64'd0);
    repeat (WORDS + 3) @(negedge clk);

    // Randomized back-to-back traffic with random consumer stalls
    base = n_acc;
    for (int c = 0; c < 40000 && (n_acc - base) < 1000; c++) begin
      @(posedge clk);
      #2;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in1       = W'($urandom);
      bus.in2       = W'($urandom);
      bus.cin       = 1'($urandom_range(0, 1));
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (WORDS + 4) @(posedge clk);
    chk("rand_count", 64'((n_acc - base) >= 1000), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
